rr_arbiter_wt: RTL and testbench
================================

Name: rr_arbiter_wt

Overview:
- Parametrised successor to the 4-way round-robin arbiter.
- N requesters, registered one-hot grant, per-channel programmable weights (consecutive-grant credits) and a lock input that holds the grant across multi-cycle transfers.
- Sits in front of shared resources (bus ports, memory banks) and replaces fixed 4-channel single-cycle rotation.

Parameters:
- N, 4, number of requesters (>=2).
- WW, 4, weight field width per channel.
- IW, $clog2(N), grant index width (derived, not overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N  request vector, bit i = channel i.
- weight  input  N*WW  flat weights; channel i at [i*WW +: WW]; sampled only when a grant is issued.
- lock  input  1  owner keeps grant regardless of credit while its req stays high.
- gnt  output  N  registered one-hot grant, all-zero when idle.
- gnt_id  output  IW  binary index of gnt; 0 when idle.
- gnt_vld  output  1  high iff gnt != 0.

Behaviour:
- Reset (rst low, async): gnt=0, gnt_id=0, gnt_vld=0, credit=0, ptr=N-1, so channel 0 has first priority after reset. Outputs go to 0 immediately, without a clock edge.
- All outputs are registered. Latency is 1 cycle: req sampled at edge k gives gnt visible after edge k.
- Internal state:
  - owner: the current gnt.
  - ptr: index of the last granted channel.
  - credit: WW-bit remaining consecutive cycles.
- Per rising edge, with o = current owner:
  - IDLE (gnt_vld=0):
    - If req==0, stay idle.
    - Otherwise grant the first set req bit searching ptr+1, ptr+2, ... wrapping modulo N.
  - HOLD (gnt_vld=1, req[o]=1, and (lock=1 or credit>1)):
    - Keep o.
    - If lock=0, credit-=1.
    - If lock=1, credit is frozen; it never underflows.
  - RELEASE (gnt_vld=1 and (req[o]=0 or (credit<=1 and lock=0))):
    - Arbitrate from o+1 wrapping. o itself has lowest priority.
    - If no req is set, go idle with gnt=0.
    - If o is the only requester, re-grant o with fresh credit; there are no bubble cycles.
- On every new grant to channel c (including a re-grant): credit=weight[c], with weight 0 treated as 1; ptr=c.
- Channel c with weight w and continuous contention receives exactly w consecutive cycles, then rotates.
- Owner dropping req mid-credit: the grant moves next edge, remaining credit is discarded, and lock has no effect.
- Lock asserted while idle or during a release edge: no effect. It only extends an existing HOLD.
- A req change on a non-owner channel never pre-empts the owner.
- Reset mid-grant: all state is cleared. The first grant after reset follows the channel-0-first rule.
- gnt is always one-hot or zero. gnt_id and gnt_vld are derived consistently from the same registered state.
- Weight changes while a grant is held do not affect the current credit.

Decomposition:
- Package rr_arb_pkg holds:
  - the default N/WW localparams;
  - a function onehot2idx(N-bit) -> IW;
  - a function rot_mask that builds the priority mask from ptr.
- Sub-module rr_prio_pick, combinational:
  - inputs: req[N] and start index;
  - outputs: one-hot pick and a found flag;
  - implementation: double-width rotate plus priority encode.
- The top level holds the credit counter, owner/ptr registers and the HOLD/RELEASE decision.

Test Plan:
- Reset: hold rst=0 with req=1111; gnt=0000, gnt_id=0, gnt_vld=0. Release rst, then req=0001; gnt=0001 one edge later. Drop req; gnt=0000 next edge.
- Fair rotation: all weights=1, req=1111 held. gnt sequence is 0001, 0010, 0100, 1000, 0001 on consecutive edges.
- Weighted: weights ch0=3, ch1=2, ch2=1, ch3=1, req=1111. Sequence is 0001 x3, 0010 x2, 0100, 1000, 0001 x3.
- Single requester and early drop:
  - req=0100, weight2=2: gnt=0100 continuously with no idle gaps.
  - Then ch0 weight=4 granted with req=0011, ch0 drops req after 1 cycle: gnt=0010 next edge.
- Lock: req=0011, weight0=1. Lock=1 from the first 0001 grant for 5 cycles keeps gnt=0001 all 5 cycles. Lock=0 gives gnt=0010 next edge.
- Async reset mid-transfer: during a 0010 hold, pulse rst low between edges. Outputs go to 0 immediately. After release with req=1111, the first grant is 0001.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared defaults and index/mask helpers for the weighted round-robin arbiter
package rr_arb_pkg;
    localparam int N_DEF = 4;
    localparam int WW_DEF = 4;
    localparam int MAXN = 64;
    localparam int IDXW = $clog2(MAXN);
    function automatic logic [IDXW-1:0] onehot2idx(input logic [MAXN-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAXN; i++) idx |= v[i] ? IDXW'(i) : '0;
        return idx;
    endfunction
    function automatic logic [MAXN-1:0] rot_mask(input int ptr, input int n);
        logic [MAXN-1:0] m;
        m = '0;
        for (int i = 0; i < MAXN; i++) m[i] = (i > ptr) && (i < n);
        return m;
    endfunction
endpackage

// File: rtl/rr_prio_pick.sv
// rr_prio_pick: lowest set request at or after start, wrapping, as a one-hot pick
module rr_prio_pick #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  pick,
    output logic          found
);
    logic [N-1:0] rot, low;
    always_comb begin
        rot = N'({req, req} >> start);
        low = rot & (-rot);
        pick = N'(({low, low} << start) >> N);
        found = |req;
    end
endmodule

// File: rtl/rr_arbiter_wt.sv
// rr_arbiter_wt: N-way round-robin arbiter with per-channel credit weights and grant lock
module rr_arbiter_wt
    import rr_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int WW = WW_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N*WW-1:0] weight,
    input  logic          lock,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_vld
);
    logic [IW-1:0] ptr, start, pick_id;
    logic [WW-1:0] credit, credit_d, w_sel;
    logic [N-1:0] pick, gnt_d;
    logic found, hold;
    rr_prio_pick #(.N(N), .IW(IW)) u_pick (
        .req(req),
        .start(start),
        .pick(pick),
        .found(found)
    );
    always_comb begin
        start = (ptr == IW'(N - 1)) ? '0 : ptr + IW'(1);
        pick_id = IW'(onehot2idx(MAXN'(pick)));
        w_sel = weight[int'(pick_id) * WW +: WW];
        hold = gnt_vld && |(req & gnt) && (lock || credit > WW'(1));
        gnt_d = hold ? gnt : pick;
        credit_d = hold ? (lock ? credit : credit - WW'(1)) : !found ? '0 : (w_sel == '0 ? WW'(1) : w_sel);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt <= '0;
            gnt_id <= '0;
            gnt_vld <= 1'b0;
            credit <= '0;
            ptr <= IW'(N - 1);
        end else begin
            gnt <= gnt_d;
            credit <= credit_d;
            if (!hold) begin
                gnt_id <= found ? pick_id : '0;
                gnt_vld <= found;
                if (found) ptr <= pick_id;
            end
        end
    end
endmodule

// File: tb/tb_rr_arbiter_wt.sv
// tb_rr_arbiter_wt: directed and random checks of rr_arbiter_wt against a behavioural model
module tb_rr_arbiter_wt;
    localparam int N = 4;
    localparam int WW = 4;
    logic clk = 0, rst = 0, lock = 0;
    logic [N-1:0] req = '1;
    logic [N*WW-1:0] weight = 16'h1111;
    logic [N-1:0] gnt;
    logic [1:0] gnt_id;
    logic gnt_vld;
    int checks = 0, failures = 0;
    int own = -1, m_ptr = N - 1, m_cred = 0;
    int base, c;
    logic [N-1:0] fair_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] wt_seq [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                  4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001};

    rr_arbiter_wt #(.N(N), .WW(WW)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .weight(weight),
        .lock(lock),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .gnt_vld(gnt_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_gnt(input string nm, input logic [N-1:0] e);
        @(negedge clk);
        check(nm, 32'(gnt), 32'(e));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
    endtask

    // Model: owner index (-1 idle), last-granted pointer, remaining credit as plain integers
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            own = -1;
            m_ptr = N - 1;
            m_cred = 0;
        end else if (own >= 0 && req[own] && (lock || m_cred > 1)) begin
            if (!lock) m_cred = m_cred - 1;
        end else begin
            base = (own >= 0) ? own : m_ptr;
            c = -1;
            for (int k = 1; k <= N; k++) if (c < 0 && req[(base + k) % N]) c = (base + k) % N;
            own = c;
            if (c >= 0) begin
                m_ptr = c;
                m_cred = int'(weight[c * WW +: WW]);
                if (m_cred == 0) m_cred = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("model_gnt", 32'(gnt), own < 0 ? 32'd0 : 32'd1 << own);
        check("model_gnt_id", 32'(gnt_id), own < 0 ? 32'd0 : 32'(own));
        check("model_gnt_vld", 32'(gnt_vld), 32'(own >= 0));
    end

    initial begin
        #7;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_gnt_vld", 32'(gnt_vld), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_gnt", 32'(gnt), 32'd0);
        rst = 1;
        req = 4'b0001;
        expect_gnt("first_ch0", 4'b0001);
        req = '0;
        expect_gnt("drop_idle", 4'b0000);

        do_reset();
        req = '1;
        weight = 16'h1111;
        for (int i = 0; i < 5; i++) expect_gnt("fair_rotation", fair_seq[i]);

        do_reset();
        weight = 16'h1123;
        for (int i = 0; i < 10; i++) expect_gnt("weighted", wt_seq[i]);

        do_reset();
        req = 4'b0100;
        weight = 16'h0200;
        repeat (6) expect_gnt("single_req", 4'b0100);

        do_reset();
        weight = 16'h0004;
        req = 4'b0011;
        expect_gnt("early_grant", 4'b0001);
        req = 4'b0010;
        expect_gnt("early_drop", 4'b0010);

        do_reset();
        weight = 16'h1111;
        req = 4'b0011;
        expect_gnt("lock_first", 4'b0001);
        lock = 1;
        repeat (5) expect_gnt("lock_hold", 4'b0001);
        lock = 0;
        expect_gnt("lock_release", 4'b0010);

        do_reset();
        weight = 16'h0040;
        req = 4'b0010;
        expect_gnt("mid_grant", 4'b0010);
        #2 rst = 0;
        #1;
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_gnt_id", 32'(gnt_id), 32'd0);
        check("async_gnt_vld", 32'(gnt_vld), 32'd0);
        req = '1;
        @(negedge clk);
        rst = 1;
        expect_gnt("post_rst_ch0", 4'b0001);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) req = N'($urandom);
            if ($urandom_range(0, 7) == 0) weight = 16'($urandom);
            lock = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 0;
                #1;
                check("rand_async_vld", 32'(gnt_vld), 32'd0);
                @(negedge clk);
                rst = 1;
            end
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
